fft16_bf_sched: RTL and testbench

- Sequencer for the radix-4 butterfly in the 16-point FFT: runs the 2-stage, 4-butterfly-per-stage in-place schedule over a 16-entry sample buffer.
- Generates 4-operand read addresses, butterfly-input valid, per-leg twiddle exponents and delayed write-back addresses.
- Sits between the start/done control interface and the sample buffer plus butterfly/twiddle datapath.

---
 rtl/fft16_bf_sched.sv | 190 +++++++++++++++++++
 tb/tb_fft16_bf_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fft16_bf_sched.sv
// rtl/fft16_bf_sched.sv - radix-4 16-point FFT butterfly schedule sequencer
// Optional feature: define FFT16_BF_SCALE_EN to add the bf_scale output.
module fft16_bf_sched #(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  output logic        bf_valid,
  output logic [15:0] tw_exp,
  output logic        wr_en,
  output logic [15:0] wr_addr
`ifdef FFT16_BF_SCALE_EN
  ,
  output logic        bf_scale
`endif
);

  // Total read-to-write latency; also the length of each drain phase.
  localparam int L  = RD_LAT + BF_LAT;
  localparam int CW = $clog2(L + 4);
  localparam logic [CW-1:0] ISS_LAST = CW'(3);
  localparam logic [CW-1:0] DRN_LAST = CW'(L - 1);

`ifdef FFT16_BF_SCALE_EN
  localparam int AW = 34;
`else
  localparam int AW = 33;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ISS0 = 3'd1,
    DRN0 = 3'd2,
    ISS1 = 3'd3,
    DRN1 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t          state, nstate;
  logic [CW-1:0]   cnt, ncnt;
  logic [15:0]     rd_tw;
  logic            nrd_en;
  logic [15:0]     nrd_addr;
  logic [15:0]     ntw;
  logic [1:0]      bi;
  logic [3:0]      b1, b2, b3;

  // Next state and phase counter.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      IDLE: if (start) begin
        nstate = ISS0;
        ncnt   = '0;
      end
      ISS0: if (cnt == ISS_LAST) begin
        nstate = DRN0;
        ncnt   = '0;
      end else begin
        ncnt = cnt + CW'(1);
      end
      DRN0: if (cnt == DRN_LAST) begin
        nstate = ISS1;
        ncnt   = '0;
      end else begin
        ncnt = cnt + CW'(1);
      end
      ISS1: if (cnt == ISS_LAST) begin
        nstate = DRN1;
        ncnt   = '0;
      end else begin
        ncnt = cnt + CW'(1);
      end
      DRN1: if (cnt == DRN_LAST) begin
        nstate = DONE;
        ncnt   = '0;
      end else begin
        ncnt = cnt + CW'(1);
      end
      DONE: begin
        nstate = IDLE;
        ncnt   = '0;
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // Read addresses and twiddle exponents for the butterfly about to issue.
  always_comb begin
    bi       = ncnt[1:0];
    b1       = {2'b00, bi};
    b2       = {1'b0, bi, 1'b0};
    b3       = b1 + b2;
    nrd_en   = 1'b0;
    nrd_addr = 16'h0000;
    ntw      = 16'h0000;
    case (nstate)
      ISS0: begin
        nrd_en   = 1'b1;
        nrd_addr = {2'd3, bi, 2'd2, bi, 2'd1, bi, 2'd0, bi};
      end
      ISS1: begin
        nrd_en   = 1'b1;
        nrd_addr = {bi, 2'd3, bi, 2'd2, bi, 2'd1, bi, 2'd0};
        ntw      = {b3, b2, b1, 4'd0};
      end
      default: begin
        nrd_en   = 1'b0;
      end
    endcase
  end

  // Schedule FSM with registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= 16'h0000;
      rd_tw   <= 16'h0000;
    end else begin
      state   <= nstate;
      cnt     <= ncnt;
      busy    <= (nstate != IDLE) && (nstate != DONE);
      done    <= (nstate == DONE);
      rd_en   <= nrd_en;
      rd_addr <= nrd_addr;
      rd_tw   <= ntw;
    end
  end

  // Read-latency pipeline: strobe, addresses and twiddles move together.
  logic [AW-1:0] pa [RD_LAT];
  logic [AW-1:0] pa_in;
  logic [AW-1:0] pa_out;

`ifdef FFT16_BF_SCALE_EN
  assign pa_in    = {rd_en, rd_en, rd_addr, rd_tw};
  assign bf_scale = pa_out[33];
`else
  assign pa_in    = {rd_en, rd_addr, rd_tw};
`endif

  // Shift the read-side pipeline; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pa[i] <= '0;
    end else begin
      pa[0] <= pa_in;
      for (int i = 1; i < RD_LAT; i++) pa[i] <= pa[i-1];
    end
  end

  assign pa_out   = pa[RD_LAT-1];
  assign bf_valid = pa_out[32];
  assign tw_exp   = pa_out[15:0];

  generate
    if (BF_LAT == 0) begin : g_nobf
      assign wr_en   = pa_out[32];
      assign wr_addr = pa_out[31:16];
    end else begin : g_bf
      logic [16:0] pb [BF_LAT];
      // Butterfly-latency pipeline carrying the in-place write addresses.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < BF_LAT; i++) pb[i] <= '0;
        end else begin
          pb[0] <= pa_out[32:16];
          for (int i = 1; i < BF_LAT; i++) pb[i] <= pb[i-1];
        end
      end
      assign wr_en   = pb[BF_LAT-1][16];
      assign wr_addr = pb[BF_LAT-1][15:0];
    end
  endgenerate

endmodule

// File: tb/tb_fft16_bf_sched.sv
// tb/tb_fft16_bf_sched.sv - directed bench for fft16_bf_sched
module tb_fft16_bf_sched;

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  logic        a_busy, a_done, a_rd_en, a_bf_valid, a_wr_en;
  logic [15:0] a_rd_addr, a_tw_exp, a_wr_addr;
  logic        b_busy, b_done, b_rd_en, b_bf_valid, b_wr_en;
  logic [15:0] b_rd_addr, b_tw_exp, b_wr_addr;
`ifdef FFT16_BF_SCALE_EN
  logic        a_bf_scale, b_bf_scale;
`endif

  int nvec = 0;
  int nbad = 0;

  logic [15:0] rdtab [8] = '{16'hC840, 16'hD951, 16'hEA62, 16'hFB73,
                             16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
  logic [15:0] twtab [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                             16'h0000, 16'h3210, 16'h6420, 16'h9630};

  always #5 clk = ~clk;

  fft16_bf_sched dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (a_busy),
    .done     (a_done),
    .rd_en    (a_rd_en),
    .rd_addr  (a_rd_addr),
    .bf_valid (a_bf_valid),
    .tw_exp   (a_tw_exp),
    .wr_en    (a_wr_en),
    .wr_addr  (a_wr_addr)
`ifdef FFT16_BF_SCALE_EN
    ,
    .bf_scale (a_bf_scale)
`endif
  );

  fft16_bf_sched #(.RD_LAT(2), .BF_LAT(0)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (b_busy),
    .done     (b_done),
    .rd_en    (b_rd_en),
    .rd_addr  (b_rd_addr),
    .bf_valid (b_bf_valid),
    .tw_exp   (b_tw_exp),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr)
`ifdef FFT16_BF_SCALE_EN
    ,
    .bf_scale (b_bf_scale)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Index of the butterfly issued on cycle k of a run with latency lat, or -1.
  function automatic int ridx(input int k, input int lat);
    if (k >= 0 && k < 4) return k;
    if (k >= lat + 4 && k < lat + 8) return k - lat;
    return -1;
  endfunction

  // One transform: start on cycle -1, check cycles 0..last.
  task automatic run_seq(input string nm, input bit sel_b, input int lat, input int rl,
                         input int p1, input int p2, input int rst_at, input int last);
    int r;
    bit dead;
    logic o_busy, o_done, o_rd, o_bv, o_wr, o_sc;
    logic [15:0] o_ra, o_tw, o_wa;
    logic e_rd, e_bv, e_wr;
    logic [15:0] e_ra, e_tw, e_wa;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      dead  = (rst_at >= 0) && (k > rst_at);
      if (sel_b) begin
        o_busy = b_busy; o_done = b_done; o_rd = b_rd_en; o_ra = b_rd_addr;
        o_bv = b_bf_valid; o_tw = b_tw_exp; o_wr = b_wr_en; o_wa = b_wr_addr;
`ifdef FFT16_BF_SCALE_EN
        o_sc = b_bf_scale;
`else
        o_sc = b_bf_valid;
`endif
      end else begin
        o_busy = a_busy; o_done = a_done; o_rd = a_rd_en; o_ra = a_rd_addr;
        o_bv = a_bf_valid; o_tw = a_tw_exp; o_wr = a_wr_en; o_wa = a_wr_addr;
`ifdef FFT16_BF_SCALE_EN
        o_sc = a_bf_scale;
`else
        o_sc = a_bf_valid;
`endif
      end
      r    = ridx(k, lat);
      e_rd = !dead && (r >= 0);
      e_ra = e_rd ? rdtab[r[2:0]] : 16'h0000;
      r    = ridx(k - rl, lat);
      e_bv = !dead && (r >= 0);
      e_tw = e_bv ? twtab[r[2:0]] : 16'h0000;
      r    = ridx(k - lat, lat);
      e_wr = !dead && (r >= 0);
      e_wa = e_wr ? rdtab[r[2:0]] : 16'h0000;
      check($sformatf("%s c%0d rd_en", nm, k),    {15'b0, o_rd},   {15'b0, e_rd});
      check($sformatf("%s c%0d rd_addr", nm, k),  o_ra,            e_ra);
      check($sformatf("%s c%0d bf_valid", nm, k), {15'b0, o_bv},   {15'b0, e_bv});
      check($sformatf("%s c%0d tw_exp", nm, k),   o_tw,            e_tw);
      check($sformatf("%s c%0d wr_en", nm, k),    {15'b0, o_wr},   {15'b0, e_wr});
      check($sformatf("%s c%0d wr_addr", nm, k),  o_wa,            e_wa);
      check($sformatf("%s c%0d done", nm, k),     {15'b0, o_done},
            {15'b0, (!dead && k == 2*lat + 8)});
      check($sformatf("%s c%0d busy", nm, k),     {15'b0, o_busy},
            {15'b0, (!dead && k <= 2*lat + 7)});
`ifdef FFT16_BF_SCALE_EN
      check($sformatf("%s c%0d bf_scale", nm, k), {15'b0, o_sc},   {15'b0, e_bv});
`else
      if (o_sc !== o_bv) check($sformatf("%s c%0d tap", nm, k), {15'b0, o_sc}, {15'b0, o_bv});
`endif
      if (k == p1 || k == p2) start = 1'b1;
      if (k == rst_at) rst_n = 1'b0;
    end
  endtask

  task automatic check_idle(input string nm);
    check({nm, " a busy"},  {15'b0, a_busy},  16'h0);
    check({nm, " a done"},  {15'b0, a_done},  16'h0);
    check({nm, " a rd_en"}, {15'b0, a_rd_en}, 16'h0);
    check({nm, " a rd_addr"}, a_rd_addr, 16'h0);
    check({nm, " a bf_valid"}, {15'b0, a_bf_valid}, 16'h0);
    check({nm, " a tw_exp"}, a_tw_exp, 16'h0);
    check({nm, " a wr_en"}, {15'b0, a_wr_en}, 16'h0);
    check({nm, " a wr_addr"}, a_wr_addr, 16'h0);
    check({nm, " b busy"},  {15'b0, b_busy},  16'h0);
    check({nm, " b rd_en"}, {15'b0, b_rd_en}, 16'h0);
    check({nm, " b bf_valid"}, {15'b0, b_bf_valid}, 16'h0);
    check({nm, " b wr_en"}, {15'b0, b_wr_en}, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Plain transform with default latencies: reads, twiddles, writes, done.
    run_seq("run1", 1'b0, 3, 1, -1, -1, -1, 15);
    // Starts while busy and in DONE are dropped; a start on cycle 15 runs fresh.
    run_seq("ign", 1'b0, 3, 1, 2, 14, -1, 14);
    run_seq("fresh", 1'b0, 3, 1, -1, -1, -1, 15);
    // Reset on cycle 5, together with a start that reset must override.
    run_seq("rst", 1'b0, 3, 1, 5, -1, 5, 12);
    run_seq("post", 1'b0, 3, 1, -1, -1, -1, 15);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("reset2");
    rst_n = 1'b1;
    // Alternate latencies on the second instance.
    run_seq("lat20", 1'b1, 2, 2, -1, -1, -1, 13);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
